// File: rtl/game_pkg.sv
// Shared definitions for the two-paddle game: match state encoding, serving side
// names and the default winning score.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic SIDE_A = 1'b0;  // bottom paddle
    localparam logic SIDE_B = 1'b1;  // top paddle

    localparam int WIN_SCORE_DEF = 5;

endpackage

// File: rtl/match_sequencer_frame_timer.sv
// Frame counter shared by the point-hold and auto-serve delays: clears on request,
// advances on an enable and flags when it sits at the supplied terminal count.
module frame_timer #(
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              en,
    input  logic [FCNT_W-1:0] term,
    output logic              done
);

    logic [FCNT_W-1:0] count_q;
    logic [FCNT_W-1:0] count_d;

    // Clear wins over the enable so a state change always restarts the count.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == term);

endmodule

// File: rtl/match_sequencer.sv
// Round/match controller: IDLE->SERVE->PLAY->POINT->OVER, scoring and serve pulse.
// Define AUTO_SERVE_EN to let SERVE launch the ball by itself after SERVE_FRAMES frames.
module match_sequencer
    import game_pkg::*;
#(
    parameter int SCORE_W      = 3,
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int HOLD_FRAMES  = 30,
    parameter int SERVE_FRAMES = 120,
    parameter int FCNT_W       = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               frame_tick,
    input  logic               start_req,
    input  logic               miss_bottom,
    input  logic               miss_top,
    output logic               play_en,
    output logic               serve_pulse,
    output logic               serve_side,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               win_a,
    output logic               win_b,
    output logic               game_over,
    output logic [2:0]         state_o
);

`ifdef AUTO_SERVE_EN
    localparam logic AUTO_SERVE = 1'b1;
`else
    localparam logic AUTO_SERVE = 1'b0;
`endif

    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
    localparam logic [FCNT_W-1:0]  HOLD_TC  = FCNT_W'(HOLD_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  SERVE_TC = FCNT_W'(SERVE_FRAMES - 1);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d;
    logic [SCORE_W-1:0] score_b_q, score_b_d;
    logic               serve_side_q, serve_side_d;
    logic               serve_pulse_q, serve_pulse_d;

    logic               fcnt_clr;
    logic               fcnt_en;
    logic [FCNT_W-1:0]  fcnt_term;
    logic               fcnt_done;
    logic               match_won;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v >= WIN_VAL) ? v : v + SCORE_W'(1);
    endfunction

    frame_timer #(
        .FCNT_W (FCNT_W)
    ) u_frame_timer (
        .clk    (clk),
        .resetn (resetn),
        .clr    (fcnt_clr),
        .en     (fcnt_en),
        .term   (fcnt_term),
        .done   (fcnt_done)
    );

    assign match_won = (score_a_q == WIN_VAL) || (score_b_q == WIN_VAL);

    // Any state change restarts the frame counter, so each timed wait starts from zero.
    assign fcnt_clr = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            score_a_q     <= '0;
            score_b_q     <= '0;
            serve_side_q  <= SIDE_A;
            serve_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_a_q     <= score_a_d;
            score_b_q     <= score_b_d;
            serve_side_q  <= serve_side_d;
            serve_pulse_q <= serve_pulse_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        score_a_d     = score_a_q;
        score_b_d     = score_b_q;
        serve_side_d  = serve_side_q;
        serve_pulse_d = 1'b0;
        fcnt_en       = 1'b0;
        fcnt_term     = HOLD_TC;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                fcnt_term = SERVE_TC;
                fcnt_en   = AUTO_SERVE && frame_tick;
                if (start_req || (AUTO_SERVE && frame_tick && fcnt_done)) begin
                    state_d       = ST_PLAY;
                    serve_pulse_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // Bottom miss wins a tie; the player who missed serves next.
                if (miss_bottom) begin
                    score_b_d    = sat_inc(score_b_q);
                    serve_side_d = SIDE_A;
                    state_d      = ST_POINT;
                end else if (miss_top) begin
                    score_a_d    = sat_inc(score_a_q);
                    serve_side_d = SIDE_B;
                    state_d      = ST_POINT;
                end
            end
            ST_POINT: begin
                fcnt_en = frame_tick;
                if (match_won) begin
                    state_d = ST_OVER;
                end else if (frame_tick && fcnt_done) begin
                    state_d = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (start_req) begin
                    score_a_d    = '0;
                    score_b_d    = '0;
                    serve_side_d = SIDE_A;
                    state_d      = ST_SERVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        play_en     = (state_q == ST_PLAY);
        game_over   = (state_q == ST_OVER);
        win_a       = (state_q == ST_OVER) && (score_a_q == WIN_VAL);
        win_b       = (state_q == ST_OVER) && (score_b_q == WIN_VAL);
        serve_pulse = serve_pulse_q;
        serve_side  = serve_side_q;
        score_a     = score_a_q;
        score_b     = score_b_q;
        state_o     = state_q;
    end

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: directed match scenarios then random play, every cycle
// compared against a game-rules model of the match.
module tb_match_sequencer;

    localparam int SCORE_W      = 3;
    localparam int WIN          = 5;
    localparam int HOLD_FRAMES  = 30;
    localparam int SERVE_FRAMES = 4;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               frame_tick = 1'b0;
    logic               start_req = 1'b0;
    logic               miss_bottom = 1'b0;
    logic               miss_top = 1'b0;
    logic               play_en, serve_pulse, serve_side, win_a, win_b, game_over;
    logic [SCORE_W-1:0] score_a, score_b;
    logic [2:0]         state_o;

    int n_checks = 0;
    int n_errors = 0;

    match_sequencer #(
        .SCORE_W      (SCORE_W),
        .WIN_SCORE    (WIN),
        .HOLD_FRAMES  (HOLD_FRAMES),
        .SERVE_FRAMES (SERVE_FRAMES),
        .FCNT_W       (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_tick  (frame_tick),
        .start_req   (start_req),
        .miss_bottom (miss_bottom),
        .miss_top    (miss_top),
        .play_en     (play_en),
        .serve_pulse (serve_pulse),
        .serve_side  (serve_side),
        .score_a     (score_a),
        .score_b     (score_b),
        .win_a       (win_a),
        .win_b       (win_b),
        .game_over   (game_over),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

`ifdef AUTO_SERVE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // Game-rules model: phase names follow the match, frames counted per phase.
    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_POINT = 3, P_OVER = 4;
    int m_phase = P_IDLE;
    int m_a = 0, m_b = 0, m_server = 0, m_frames = 0, m_pulse = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic enter(input int phase);
        m_phase  = phase;
        m_frames = 0;
    endtask

    task automatic model_step(input bit rn, input bit tk, input bit st, input bit mb, input bit mt);
        if (!rn) begin
            m_a = 0; m_b = 0; m_server = 0; m_pulse = 0;
            enter(P_IDLE);
            return;
        end
        m_pulse = 0;
        case (m_phase)
            P_IDLE: if (st) enter(P_SERVE);
            P_SERVE: begin
                if (AUTO && tk) m_frames++;
                if (st || (AUTO && m_frames == SERVE_FRAMES)) begin
                    m_pulse = 1;
                    enter(P_PLAY);
                end
            end
            P_PLAY: begin
                if (mb || mt) begin
                    if (mb) begin
                        m_b = (m_b < WIN) ? m_b + 1 : m_b;
                        m_server = 0;
                    end else begin
                        m_a = (m_a < WIN) ? m_a + 1 : m_a;
                        m_server = 1;
                    end
                    $display("point: score A=%0d B=%0d, next server %0d", m_a, m_b, m_server);
                    enter(P_POINT);
                end
            end
            P_POINT: begin
                if (m_a == WIN || m_b == WIN) enter(P_OVER);
                else begin
                    if (tk) m_frames++;
                    if (m_frames == HOLD_FRAMES) enter(P_SERVE);
                end
            end
            default: begin
                if (st) begin
                    m_a = 0; m_b = 0; m_server = 0;
                    enter(P_SERVE);
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_val("state_o", int'(state_o), m_phase);
        check_val("score_a", int'(score_a), m_a);
        check_val("score_b", int'(score_b), m_b);
        check_val("serve_side", int'(serve_side), m_server);
        check_val("serve_pulse", int'(serve_pulse), m_pulse);
        check_val("play_en", int'(play_en), int'(m_phase == P_PLAY));
        check_val("game_over", int'(game_over), int'(m_phase == P_OVER));
        check_val("win_a", int'(win_a), int'(m_phase == P_OVER && m_a == WIN));
        check_val("win_b", int'(win_b), int'(m_phase == P_OVER && m_b == WIN));
    endtask

    task automatic step(input bit rn, input bit tk, input bit st, input bit mb, input bit mt);
        resetn = rn; frame_tick = tk; start_req = st; miss_bottom = mb; miss_top = mt;
        @(posedge clk);
        model_step(rn, tk, st, mb, mt);
        @(negedge clk);
        compare_all();
    endtask

    // Feed frame ticks until the model leaves POINT; bounded so a stuck DUT still ends.
    task automatic finish_point();
        int guard = 0;
        while (m_phase == P_POINT && guard < 200) begin
            step(1, 1, 0, 0, 0);
            guard++;
        end
        check_val("point_exit_bound", int'(guard < 200), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for two clocks
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0);
        check_val("reset_state", int'(state_o), 0);
        check_val("reset_pulse", int'(serve_pulse), 0);
        $display("scenario 1: reset done");

        // Start in IDLE, serve from SERVE
        step(1, 0, 1, 0, 0);
        check_val("idle_to_serve", int'(state_o), 1);
        step(1, 0, 1, 0, 0);
        check_val("serve_to_play", int'(state_o), 2);
        check_val("first_serve_pulse", int'(serve_pulse), 1);
        check_val("first_play_en", int'(play_en), 1);
        step(1, 0, 1, 0, 0);
        check_val("pulse_one_cycle", int'(serve_pulse), 0);
        $display("scenario 2: serve done");

        // Top miss scores A; misses during the hold are ignored
        step(1, 0, 0, 0, 1);
        check_val("score_a_after_top_miss", int'(score_a), 1);
        check_val("side_after_top_miss", int'(serve_side), 1);
        for (int i = 0; i < HOLD_FRAMES; i++) begin
            step(1, 1, 0, int'(i == 3), int'(i == 7));
            if (i == HOLD_FRAMES - 2) check_val("hold_not_done", int'(state_o), 3);
        end
        check_val("hold_to_serve", int'(state_o), 1);
        check_val("score_a_held", int'(score_a), 1);
        $display("scenario 3: point hold done");

        // Simultaneous misses: only B scores
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1);
        check_val("tie_score_b", int'(score_b), 1);
        check_val("tie_score_a", int'(score_a), 1);
        $display("scenario 4: simultaneous miss done");

        // B plays to the winning score
        while (m_b < WIN) begin
            finish_point();
            step(1, 0, 1, 0, 0);
            step(1, 0, 0, 1, 0);
        end
        step(1, 0, 0, 0, 0);
        check_val("over_state", int'(state_o), 4);
        check_val("over_win_b", int'(win_b), 1);
        check_val("over_game_over", int'(game_over), 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, int'(i[0]), int'(!i[0]));
        check_val("over_frozen_b", int'(score_b), WIN);
        step(1, 0, 1, 0, 0);
        check_val("restart_state", int'(state_o), 1);
        check_val("restart_score_b", int'(score_b), 0);
        $display("scenario 5: match over and restart done");

        // SERVE without start_req
        if (AUTO) begin
            for (int i = 0; i < SERVE_FRAMES; i++) step(1, 1, 0, 0, 0);
            check_val("auto_serve_pulse", int'(serve_pulse), 1);
        end else begin
            for (int i = 0; i < 200; i++) step(1, 1, 0, 0, 0);
            check_val("no_auto_serve", int'(state_o), 1);
        end
        $display("scenario 6: serve wait done");

        // Reset mid-match
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        check_val("midreset_state", int'(state_o), 0);
        check_val("midreset_score_a", int'(score_a), 0);
        $display("scenario 7: mid-match reset done");

        // Random play
        for (int i = 0; i < 5000; i++) begin
            step($urandom_range(599, 0) != 0,
                 $urandom_range(2, 0) == 0,
                 $urandom_range(7, 0) == 0,
                 $urandom_range(9, 0) == 0,
                 $urandom_range(9, 0) == 0);
        end
        $display("scenario 8: random play done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
